// File: rtl/conv_acc_sched_if.sv
// Handshake and data bundle between the convolution accumulator scheduler,
// its controlling logic, the multiplier array and the adder tree.
// master: the surrounding environment; slave: conv_acc_sched.
interface conv_acc_sched_if;
    logic               start;
    logic [7:0]         num_grp;
    logic signed [15:0] bias;
    logic               mul_rdy;
    logic               mul_take;
    logic               tree_vld;
    logic signed [20:0] tree_acc;
    logic               out_vld;
    logic               out_rdy;
    logic signed [29:0] out_data;
    logic               busy;
    logic               done;
    logic               err;

    modport master (
        output start, num_grp, bias, mul_rdy, tree_vld, tree_acc, out_rdy,
        input  mul_take, out_vld, out_data, busy, done, err
    );

    modport slave (
        input  start, num_grp, bias, mul_rdy, tree_vld, tree_acc, out_rdy,
        output mul_take, out_vld, out_data, busy, done, err
    );
endinterface

// File: rtl/conv_acc_sched.sv
// Convolution accumulator scheduler: issues 27-product groups from the
// multiplier array into the adder tree, accumulates tree results onto the
// bias and hands the finished pixel downstream with a valid/ready handshake.
// The controller follows tree_vld only, so the adder-tree latency is free.
// Optional feature: define CONV_ACC_RELU_EN to clamp negative results to 0.
module conv_acc_sched (
    input  logic             clk,
    input  logic             rstn,
    conv_acc_sched_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        OUT   = 2'd3
    } state_t;

    state_t             state_r;
    logic [7:0]         ngrp_r;
    logic [7:0]         issue_cnt_r;
    logic [7:0]         recv_cnt_r;
    logic signed [29:0] acc_r;
    logic signed [29:0] out_data_r;
    logic               out_vld_r;
    logic               done_r;
    logic               err_r;
    logic               busy_r;

    logic               mul_take_s;
    logic               tree_ok_s;
    logic               tree_bad_s;
    logic signed [29:0] acc_sum_s;

    // Output stage transform applied to the final accumulator value.
    function automatic logic signed [29:0] out_sel_f(input logic signed [29:0] a);
`ifdef CONV_ACC_RELU_EN
        if (a[29]) begin
            return 30'sd0;
        end else begin
            return a;
        end
`else
        return a;
`endif
    endfunction

    // Take decision, tree-result acceptance/rejection and the next sum.
    always_comb begin
        mul_take_s = 1'b0;
        tree_ok_s  = 1'b0;
        tree_bad_s = 1'b0;
        acc_sum_s  = acc_r + {{9{bus.tree_acc[20]}}, bus.tree_acc};
        if ((state_r == ISSUE) && bus.mul_rdy && (issue_cnt_r < ngrp_r)) begin
            mul_take_s = 1'b1;
        end else begin
            mul_take_s = 1'b0;
        end
        // A result is only legal while groups are outstanding; compare with
        // the pre-take issue count so a same-cycle take does not cover it.
        if (bus.tree_vld) begin
            if (((state_r == ISSUE) || (state_r == DRAIN)) && (recv_cnt_r < issue_cnt_r)) begin
                tree_ok_s = 1'b1;
            end else begin
                tree_bad_s = 1'b1;
            end
        end else begin
            tree_ok_s  = 1'b0;
            tree_bad_s = 1'b0;
        end
    end

    // Scheduler FSM with its counters, accumulator and registered outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r     <= IDLE;
            ngrp_r      <= 8'd1;
            issue_cnt_r <= 8'd0;
            recv_cnt_r  <= 8'd0;
            acc_r       <= 30'sd0;
            out_data_r  <= 30'sd0;
            out_vld_r   <= 1'b0;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (tree_bad_s) begin
                err_r <= 1'b1;
            end
            case (state_r)
                IDLE: begin
                    if (bus.start) begin
                        ngrp_r      <= (bus.num_grp == 8'd0) ? 8'd1 : bus.num_grp;
                        acc_r       <= {{14{bus.bias[15]}}, bus.bias};
                        issue_cnt_r <= 8'd0;
                        recv_cnt_r  <= 8'd0;
                        busy_r      <= 1'b1;
                        state_r     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (mul_take_s) begin
                        issue_cnt_r <= issue_cnt_r + 8'd1;
                    end
                    if (tree_ok_s) begin
                        acc_r      <= acc_sum_s;
                        recv_cnt_r <= recv_cnt_r + 8'd1;
                    end
                    if (mul_take_s && ((issue_cnt_r + 8'd1) == ngrp_r)) begin
                        state_r <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (tree_ok_s) begin
                        acc_r      <= acc_sum_s;
                        recv_cnt_r <= recv_cnt_r + 8'd1;
                        if ((recv_cnt_r + 8'd1) == ngrp_r) begin
                            out_data_r <= out_sel_f(acc_sum_s);
                            out_vld_r  <= 1'b1;
                            state_r    <= OUT;
                        end
                    end
                end
                OUT: begin
                    if (bus.out_rdy) begin
                        out_vld_r <= 1'b0;
                        done_r    <= 1'b1;
                        busy_r    <= 1'b0;
                        state_r   <= IDLE;
                    end
                end
                default: begin
                    out_vld_r <= 1'b0;
                    busy_r    <= 1'b0;
                    state_r   <= IDLE;
                end
            endcase
        end
    end

    assign bus.mul_take = mul_take_s;
    assign bus.out_vld  = out_vld_r;
    assign bus.out_data = out_data_r;
    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.err      = err_r;

endmodule
